// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and the imem read port,
// and hands {instr, pc} pairs to decode through a 2-entry buffer.
module fetch_stage #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  pc_out
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [1:0]        count;
  entry_t            slot0;
  entry_t            slot1;
  entry_t            resp;

  logic room;
  logic pop;
  logic push;
  logic issue;

  // count + inflight never exceeds 2, so a 2-bit sum is exact
  assign room  = (count + {1'b0, inflight}) < 2'd2;
  assign pop   = if_valid && if_ready;
  assign push  = inflight;
  assign issue = !rst && !br_taken && (room || pop);

  assign imem_req  = issue;
  assign pc_out    = rst ? RESET_PC : fetch_pc;
  assign imem_addr = pc_out;

  assign if_valid = !rst && (count != 2'd0);
  assign if_instr = rst ? '0 : slot0.instr;
  assign if_pc    = rst ? '0 : slot0.pc;

  assign resp = '{instr: imem_rdata, pc: inflight_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      slot0       <= '0;
      slot1       <= '0;
    end else if (br_taken) begin
      // flush: the response of the read in flight is dropped
      fetch_pc <= br_target;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(1);
      end
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= resp;
          else               slot1 <= resp;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= resp;
          end else begin
            slot0 <= slot1;
            slot1 <= resp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every
// cycle, directed literal checks, and a wrap-around instance.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br = 1'b0;
  logic [7:0]  tgt = 8'h00;
  logic        rdy = 1'b1;

  logic        req0, req1;
  logic [7:0]  addr0, addr1;
  logic [15:0] rdata0 = '0, rdata1 = '0;
  logic        valid0, valid1;
  logic [15:0] instr0, instr1;
  logic [7:0]  ifpc0, ifpc1;
  logic [7:0]  pcout0, pcout1;

  int tests = 0;
  int fails = 0;
  bit mon = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u0 (
    .clk(clk), .rst(rst), .br_taken(br), .br_target(tgt),
    .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
    .if_valid(valid0), .if_ready(rdy), .if_instr(instr0),
    .if_pc(ifpc0), .pc_out(pcout0)
  );

  fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) u1 (
    .clk(clk), .rst(rst), .br_taken(br), .br_target(tgt),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .if_valid(valid1), .if_ready(rdy), .if_instr(instr1),
    .if_pc(ifpc1), .pc_out(pcout1)
  );

  // imem: mem[a] = 0x1000 + a, one-cycle read latency
  always @(posedge clk) begin
    rdata0 <= 16'h1000 + {8'h00, addr0};
    rdata1 <= 16'h1000 + {8'h00, addr1};
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: pcs waiting for decode, plus one outstanding read
  logic [7:0] mq[$];
  logic [7:0] mpc = 8'h00;
  bit         minf = 1'b0;
  logic [7:0] minfpc = 8'h00;

  function automatic bit m_req();
    bit p;
    p = !rst && mq.size() > 0 && rdy;
    return !rst && !br && ((mq.size() + int'(minf) < 2) || p);
  endfunction

  always @(posedge clk) begin : model
    bit p, r;
    p = !rst && mq.size() > 0 && rdy;
    r = m_req();
    if (rst) begin
      mpc = 8'h00; mq.delete(); minf = 1'b0;
    end else if (br) begin
      mpc = tgt; mq.delete(); minf = 1'b0;
    end else begin
      if (p) void'(mq.pop_front());
      if (minf) mq.push_back(minfpc);
      if (r) begin
        minfpc = mpc;
        mpc = mpc + 8'd1;
      end
      minf = r;
    end
  end

  always @(negedge clk) begin : compare
    bit ev;
    logic [7:0] ea;
    if (mon) begin
      ev = !rst && mq.size() > 0;
      ea = rst ? 8'h00 : mpc;
      chk("m_req", {31'd0, req0}, {31'd0, m_req()});
      chk("m_addr", {24'd0, addr0}, {24'd0, ea});
      chk("m_pcout", {24'd0, pcout0}, {24'd0, ea});
      chk("m_valid", {31'd0, valid0}, {31'd0, ev});
      if (ev) begin
        chk("m_pc", {24'd0, ifpc0}, {24'd0, mq[0]});
        chk("m_instr", {16'd0, instr0}, 32'h1000 + {24'd0, mq[0]});
      end else if (rst) begin
        chk("m_rst_pc", {24'd0, ifpc0}, 32'd0);
        chk("m_rst_instr", {16'd0, instr0}, 32'd0);
      end
    end
  end

  // first four pcs delivered by the RESET_PC=0xFE instance
  logic [7:0] wq[$];
  always @(negedge clk)
    if (mon && !rst && valid1 && rdy && wq.size() < 4)
      wq.push_back(ifpc1);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk(nm, act, exp);
  endtask

  initial begin
    cyc();
    mon = 1'b1;
    cyc();
    #2;
    lit("rst_req", {31'd0, req0}, 32'd0);
    lit("rst_valid", {31'd0, valid0}, 32'd0);
    lit("rst_pcout1", {24'd0, pcout1}, 32'hFE);

    // cycle 0: release
    cyc(); rst = 1'b0; #2;
    lit("c0_req", {31'd0, req0}, 32'd1);
    lit("c0_addr", {24'd0, addr0}, 32'h00);
    cyc(); #2;
    lit("c1_addr", {24'd0, addr0}, 32'h01);
    lit("c1_valid", {31'd0, valid0}, 32'd0);
    cyc(); #2;
    lit("c2_addr", {24'd0, addr0}, 32'h02);
    lit("c2_valid", {31'd0, valid0}, 32'd1);
    lit("c2_pc", {24'd0, ifpc0}, 32'h00);
    lit("c2_instr", {16'd0, instr0}, 32'h1000);

    // cycles 3..7: backpressure
    for (int i = 0; i < 5; i++) begin
      cyc(); rdy = 1'b0; #2;
      lit("bp_pc", {24'd0, ifpc0}, 32'h01);
      if (i > 0) lit("bp_req", {31'd0, req0}, 32'd0);
    end
    cyc(); rdy = 1'b1; #2;
    lit("c8_pc", {24'd0, ifpc0}, 32'h01);
    lit("c8_addr", {24'd0, addr0}, 32'h03);
    cyc(); #2;
    lit("c9_pc", {24'd0, ifpc0}, 32'h02);
    cyc(); #2;
    lit("c10_pc", {24'd0, ifpc0}, 32'h03);

    // cycle 11: redirect with a head entry and a read in flight
    cyc(); br = 1'b1; tgt = 8'h40; #2;
    lit("br_req", {31'd0, req0}, 32'd0);
    lit("br_valid", {31'd0, valid0}, 32'd1);
    cyc(); br = 1'b0; tgt = 8'h00; #2;
    lit("br1_valid", {31'd0, valid0}, 32'd0);
    lit("br1_addr", {24'd0, addr0}, 32'h40);
    cyc(); #2;
    lit("br2_valid", {31'd0, valid0}, 32'd0);
    cyc(); #2;
    lit("br3_valid", {31'd0, valid0}, 32'd1);
    lit("br3_pc", {24'd0, ifpc0}, 32'h40);
    lit("br3_instr", {16'd0, instr0}, 32'h1040);
    cyc(); #2;
    lit("br4_pc", {24'd0, ifpc0}, 32'h41);

    // reset mid-stream with a full buffer
    cyc(); rdy = 1'b0;
    cyc(); rst = 1'b1; #2;
    lit("mr_valid", {31'd0, valid0}, 32'd0);
    lit("mr_req", {31'd0, req0}, 32'd0);
    cyc(); rst = 1'b0; rdy = 1'b1; #2;
    lit("mr1_addr", {24'd0, addr0}, 32'h00);
    lit("mr1_valid", {31'd0, valid0}, 32'd0);
    cyc(); #2;
    lit("mr2_valid", {31'd0, valid0}, 32'd0);
    cyc(); #2;
    lit("mr3_pc", {24'd0, ifpc0}, 32'h00);

    // reset and redirect together: reset wins
    cyc(); rst = 1'b1; br = 1'b1; tgt = 8'h40; #2;
    lit("rb_req", {31'd0, req0}, 32'd0);
    cyc(); rst = 1'b0; br = 1'b0; tgt = 8'h00; #2;
    lit("rb_addr", {24'd0, addr0}, 32'h00);
    lit("rb_req1", {31'd0, req0}, 32'd1);

    // mixed traffic, checked by the model alone
    for (int i = 0; i < 80; i++) begin
      cyc();
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 11) == 0);
      tgt = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 39) == 0);
    end
    cyc(); rst = 1'b0; br = 1'b0; rdy = 1'b1;
    repeat (4) cyc();

    lit("wrap_cnt", wq.size(), 32'd4);
    if (wq.size() == 4) begin
      lit("wrap0", {24'd0, wq[0]}, 32'hFE);
      lit("wrap1", {24'd0, wq[1]}, 32'hFF);
      lit("wrap2", {24'd0, wq[2]}, 32'h00);
      lit("wrap3", {24'd0, wq[3]}, 32'h01);
    end

    mon = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
